// File: rtl/apb4_plic_param_if.sv
// APB4 bus bundle between a requester and the PLIC register file.
interface apb4_plic_param_if;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_plic_param.sv
// APB4 platform-level interrupt controller with per-target claim/complete.
// Define PLIC_EDGE_TRIG_EN to add per-source rising-edge gateways selected by TRIG.
module apb4_plic_param #(
  parameter int SRC_NUM    = 32,
  parameter int PRIO_WIDTH = 3,
  parameter int TGT_NUM    = 2
) (
  input  logic               pclk,
  input  logic               prst,
  apb4_plic_param_if.slave   apb,
  input  logic [SRC_NUM-1:0] irq_i,
  output logic [TGT_NUM-1:0] ext_irq_o
);
  localparam int ID_W = $clog2(SRC_NUM);
  localparam logic [SRC_NUM-1:0] SRC_MASK = ~SRC_NUM'(1);

  logic                  access, rd, wr;
  logic [9:0]            word;
  logic [4:0]            src_idx;
  logic [2:0]            tgt_idx;
  logic                  prio_rgn, tgt_rgn, tgt_ok;
  logic                  sel_prio, sel_ip, sel_trig, sel_ie, sel_thold, sel_claim, mapped;
  logic [31:0]           rdata;

  logic [PRIO_WIDTH-1:0] prio [SRC_NUM];
  logic [SRC_NUM-1:0]    ie [TGT_NUM];
  logic [PRIO_WIDTH-1:0] thold [TGT_NUM];
  logic [SRC_NUM-1:0]    ip, busy;
  logic [SRC_NUM-1:0]    set_vec, claim_vec, complete_vec, ie_sel, trig_rd;
  logic [ID_W-1:0]       best [TGT_NUM];
  logic [ID_W-1:0]       claim_id;
  logic                  unused_addr_bits;

  assign access  = apb.psel & apb.penable;
  assign rd      = access & ~apb.pwrite;
  assign wr      = access & apb.pwrite;
  assign word    = apb.paddr[11:2];
  assign src_idx = word[4:0];
  assign tgt_idx = word[4:2];
  assign unused_addr_bits = ^apb.paddr[1:0];

  assign prio_rgn  = (word[9:5] == 5'd0);
  assign tgt_rgn   = (word[9:5] == 5'd2);
  assign tgt_ok    = tgt_rgn && (int'(tgt_idx) < TGT_NUM);
  assign sel_prio  = prio_rgn && (int'(src_idx) < SRC_NUM);
  assign sel_ip    = (word == 10'h020);
  assign sel_trig  = (word == 10'h021);
  assign sel_ie    = tgt_ok && (word[1:0] == 2'd0);
  assign sel_thold = tgt_ok && (word[1:0] == 2'd1);
  assign sel_claim = tgt_ok && (word[1:0] == 2'd2);
  assign mapped    = sel_prio | sel_ip | sel_trig | sel_ie | sel_thold | sel_claim;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access && !mapped && !prst;
  assign apb.prdata  = (rd && !prst) ? rdata : 32'd0;

  // Highest priority wins; strict compare keeps the lowest ID on ties and
  // doubles as the PRIO>0 / PRIO>THOLD qualification.
  always_comb begin
    logic [PRIO_WIDTH-1:0] bp;
    for (int t = 0; t < TGT_NUM; t++) begin
      best[t] = '0;
      bp      = thold[t];
      for (int i = 1; i < SRC_NUM; i++) begin
        if (ip[i] && ie[t][i] && (prio[i] > bp)) begin
          best[t] = ID_W'(i);
          bp      = prio[i];
        end
      end
    end
  end

  always_comb begin
    claim_id     = '0;
    ie_sel       = '0;
    claim_vec    = '0;
    complete_vec = '0;
    for (int t = 0; t < TGT_NUM; t++) begin
      if (tgt_idx == 3'(t)) begin
        claim_id = best[t];
        ie_sel   = ie[t];
      end
    end
    for (int i = 1; i < SRC_NUM; i++) begin
      claim_vec[i]    = rd && sel_claim && (claim_id == ID_W'(i));
      complete_vec[i] = wr && sel_claim && (apb.pwdata == 32'(i)) && ie_sel[i];
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_prio) begin
      for (int i = 1; i < SRC_NUM; i++)
        if (src_idx == 5'(i)) rdata = 32'(prio[i]);
    end
    if (sel_ip)   rdata = 32'(ip);
    if (sel_trig) rdata = 32'(trig_rd);
    for (int t = 0; t < TGT_NUM; t++) begin
      if (tgt_idx == 3'(t)) begin
        if (sel_ie)    rdata = 32'(ie[t]);
        if (sel_thold) rdata = 32'(thold[t]);
        if (sel_claim) rdata = 32'(best[t]);
      end
    end
  end

`ifdef PLIC_EDGE_TRIG_EN
  logic [SRC_NUM-1:0] trig_mode, irq_q;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      trig_mode <= '0;
      irq_q     <= '0;
    end else begin
      irq_q <= irq_i;
      if (wr && sel_trig) trig_mode <= apb.pwdata[SRC_NUM-1:0] & SRC_MASK;
    end
  end

  assign trig_rd = trig_mode;
  assign set_vec = ((trig_mode & irq_i & ~irq_q) | (~trig_mode & irq_i)) & ~busy & SRC_MASK;
`else
  assign trig_rd = '0;
  assign set_vec = irq_i & ~busy & SRC_MASK;
`endif

  // A claim clear overrides a same-edge set; busy alone gates new sets.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      ip        <= '0;
      busy      <= '0;
      ext_irq_o <= '0;
      for (int i = 0; i < SRC_NUM; i++) prio[i] <= '0;
      for (int t = 0; t < TGT_NUM; t++) begin
        ie[t]    <= '0;
        thold[t] <= '0;
      end
    end else begin
      ip   <= (ip | set_vec) & ~claim_vec;
      busy <= (busy | claim_vec) & ~complete_vec;
      for (int i = 1; i < SRC_NUM; i++)
        if (wr && sel_prio && (src_idx == 5'(i))) prio[i] <= apb.pwdata[PRIO_WIDTH-1:0];
      for (int t = 0; t < TGT_NUM; t++) begin
        if (wr && sel_ie && (tgt_idx == 3'(t)))    ie[t]    <= apb.pwdata[SRC_NUM-1:0] & SRC_MASK;
        if (wr && sel_thold && (tgt_idx == 3'(t))) thold[t] <= apb.pwdata[PRIO_WIDTH-1:0];
        ext_irq_o[t] <= |best[t];
      end
    end
  end
endmodule

// File: doc/apb4_plic_param.md
APB4_PLIC_PARAM -- requirements
Module: apb4_plic_param

Interface
REQ-001 SHALL have parameter SRC_NUM, default 32: interrupt sources including reserved ID 0; legal range 2..32.
REQ-002 SHALL have parameter PRIO_WIDTH, default 3: priority and threshold width; legal range 1..8.
REQ-003 SHALL have parameter TGT_NUM, default 2: interrupt targets (contexts); legal range 1..8.
REQ-004 Clocking and reset are decided: one clock; reset is asynchronous and active-high.
REQ-005 Port pclk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port prst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port paddr, input, 12 bits: APB4 byte address; bits [1:0] ignored.
REQ-008 Ports psel, penable, pwrite, input, 1 bit each: APB4 control.
REQ-009 Port pwdata, input, 32 bits: APB4 write data.
REQ-010 Port prdata, output, 32 bits: APB4 read data.
REQ-011 Port pready, output, 1 bit: APB4 ready.
REQ-012 Port pslverr, output, 1 bit: APB4 error.
REQ-013 Port irq_i, input, SRC_NUM bits: device interrupt lines, synchronous to pclk; bit 0 ignored.
REQ-014 Port ext_irq_o, output, TGT_NUM bits: per-target external interrupt request.

Function
REQ-015 pready SHALL be constant 1; access completes when psel&penable.
REQ-016 Register map: PRIO[i] at 0x000+4*i; IP at 0x080 (read-only); TRIG at 0x084; per target t: IE_t at 0x100+0x10*t, THOLD_t at +0x4, CLAIMCOMP_t at +0x8.
REQ-017 Accesses to unmapped addresses, i>=SRC_NUM or t>=TGT_NUM SHALL set pslverr=1 and return prdata=0; writes there have no effect.
REQ-018 Writes SHALL store pwdata[PRIO_WIDTH-1:0] into PRIO/THOLD; PRIO[0], IE bit 0, IE bits >=SRC_NUM and IP SHALL read 0 or be ignored.
REQ-019 prdata SHALL be 0 outside a read handshake.
REQ-020 Gateway, level mode: ip[i] SHALL be set at the edge where irq_i[i]=1, ip[i]=0 and busy[i]=0.
REQ-021 Claim: a read of CLAIMCOMP_t SHALL return the combinational best ID for t; if it is nonzero, ip[ID] SHALL be cleared and busy[ID] set at that edge.
REQ-022 Best ID for t: the source with ip=1, IE_t=1, PRIO>0 and PRIO>THOLD_t that has maximum PRIO. Ties SHALL go to the lowest ID. With no candidate the best ID SHALL be 0, and a claim returning 0 SHALL have no side effect.
REQ-023 Complete: a write of ID to CLAIMCOMP_t SHALL clear busy[ID] only if 0<ID<SRC_NUM and IE_t[ID]=1; otherwise it is ignored. No pslverr.
REQ-024 Complete and re-assertion: if irq_i[ID] is still high, ip[ID] SHALL set at the edge after busy clears, not the same edge.
REQ-025 ext_irq_o[t] SHALL be registered: high in the cycle after the best ID for t becomes nonzero, and low in the cycle after it becomes 0.
REQ-026 Latency: irq_i high sampled at edge N gives ip at N and ext_irq_o high after N+1.
REQ-027 Claim and IP set on the same edge: the clear for the claimed ID SHALL win. busy blocks a new set.

Reset
REQ-028 While prst=1: PRIO, IP, IE, THOLD, busy, TRIG, edge history and ext_irq_o SHALL be 0. prdata=0 and pslverr=0.
REQ-029 Reset asserted mid-claim SHALL discard all busy state. After release, sources are claimable again.

Configuration
REQ-030 Macro PLIC_EDGE_TRIG_EN is defined: TRIG is read/write, bit i=1 selects rising-edge mode. A rising edge (irq_i&~irq_q) with busy[i]=0 sets ip[i]. Edges while ip=1 merge. Edges while busy=1 are lost.
REQ-031 Macro PLIC_EDGE_TRIG_EN is undefined: TRIG SHALL read 0 and ignore writes without pslverr. All sources are level mode and no edge-history flops exist.

Verification
REQ-032 Reset check: after reset, read every register -> all 0; ext_irq_o=0; unmapped read 0x0FC -> pslverr=1, prdata=0.
REQ-033 Single IRQ: PRIO[3]=2, IE_0=0x8, THOLD_0=1, irq_i[3]=1 -> ext_irq_o[0]=1 two edges later; read CLAIMCOMP_0 -> 3, IP=0. Then write 3 -> source re-pends while irq_i[3] high.
REQ-034 Arbitration: PRIO[5]=4, PRIO[9]=4, PRIO[2]=3, all pending and enabled -> claims return 5, then 9, then 2, then 0.
REQ-035 Threshold and multi-target: PRIO[7]=3, IE_0 and IE_1 bit 7 set, THOLD_0=3, THOLD_1=2 -> ext_irq_o=2'b10. Claim by target 1 -> 7; an immediate claim by target 0 -> 0.
REQ-036 Bad completion: write 7 to CLAIMCOMP_0 with IE_0[7]=0 -> busy[7] stays, no re-pend. Write 40 -> ignored.
REQ-037 With PLIC_EDGE_TRIG_EN: TRIG[4]=1, pulse irq_i[4] for one cycle -> ip[4]=1. A second pulse before completion -> lost. A pulse after completion -> ip[4]=1.
